// File: rtl/branch_pkg.sv
// Shared definitions for the miniRISC branch-resolution stage:
// branch opcodes, flag bit positions and the resolve FSM state type.
package branch_pkg;

  localparam logic [5:0] OP_BLTZ = 6'b000111;
  localparam logic [5:0] OP_BZ   = 6'b001000;
  localparam logic [5:0] OP_BNZ  = 6'b001001;
  localparam logic [5:0] OP_BR   = 6'b001010;
  localparam logic [5:0] OP_B    = 6'b001011;
  localparam logic [5:0] OP_BL   = 6'b001100;
  localparam logic [5:0] OP_BCY  = 6'b001101;
  localparam logic [5:0] OP_BNCY = 6'b001110;

  localparam int FLAG_SIGN  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 0;

  typedef enum logic {IDLE, FLUSH} state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: (opcode, S, C, Z) -> taken.
// is_branch flags opcodes that belong to the branch group at all.
module branch_cond
  import branch_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       s,
  input  logic       c,
  input  logic       z,
  output logic       taken,
  output logic       is_branch
);

  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b1;
    case (opcode)
      OP_BLTZ: taken = s & ~z;
      OP_BZ:   taken = ~s & z;
      OP_BNZ:  taken = ~z;
      OP_BR:   taken = 1'b1;
      OP_B:    taken = 1'b1;
      OP_BL:   taken = 1'b1;
      OP_BCY:  taken = c;
      OP_BNCY: taken = ~c;
      default: is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution: flag register, condition check, redirect/link
// pulse and a FLUSH_CYCLES-long flush window. BRANCH_STATS_EN adds counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int PC_INC       = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic              sign_in,
  input  logic              carry_in,
  input  logic              zero_in,
  input  logic              br_valid,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] offset,
  input  logic [DATA_W-1:0] rs_val,
  output logic              busy,
  output logic              redirect,
  output logic [ADDR_W-1:0] target,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic [2:0]        flags
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_taken
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]         r_flags;
  logic               r_redirect, r_link_we;
  logic [ADDR_W-1:0]  r_target, r_link_addr;

  logic [2:0]         w_eff;
  logic               w_taken, w_is_branch, w_accept, w_take, w_is_bl;
  logic [ADDR_W-1:0]  w_target;

  // Same-cycle flag write is bypassed into the condition check.
  assign w_eff = flag_we ? {sign_in, carry_in, zero_in} : r_flags;

  branch_cond u_cond (
    .opcode    (opcode),
    .s         (w_eff[FLAG_SIGN]),
    .c         (w_eff[FLAG_CARRY]),
    .z         (w_eff[FLAG_ZERO]),
    .taken     (w_taken),
    .is_branch (w_is_branch)
  );

  assign w_accept = br_valid & (r_state == IDLE);
  assign w_take   = w_accept & w_taken;
  assign w_is_bl  = (opcode == OP_BL);
  assign w_target = (opcode == OP_BR) ? rs_val[ADDR_W-1:0] : pc + offset;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (w_take) begin
        w_state_nxt = FLUSH;
        w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_flags     <= '0;
      r_redirect  <= 1'b0;
      r_link_we   <= 1'b0;
      r_target    <= '0;
      r_link_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_redirect <= w_take;
      r_link_we  <= w_take & w_is_bl;
      if (flag_we)           r_flags     <= {sign_in, carry_in, zero_in};
      if (w_take)            r_target    <= w_target;
      if (w_take & w_is_bl)  r_link_addr <= pc + ADDR_W'(PC_INC);
    end
  end

  assign busy      = (r_state == FLUSH);
  assign flush     = (r_state == FLUSH);
  assign redirect  = r_redirect;
  assign link_we   = r_link_we;
  assign target    = r_target;
  assign link_addr = r_link_addr;
  assign flags     = r_flags;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_res, r_stat_tak;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_res <= '0;
      r_stat_tak <= '0;
    end else begin
      if (w_accept & w_is_branch & ~&r_stat_res) r_stat_res <= r_stat_res + 1'b1;
      if (w_take & ~&r_stat_tak)                 r_stat_tak <= r_stat_tak + 1'b1;
    end
  end

  assign stat_resolved = r_stat_res;
  assign stat_taken    = r_stat_tak;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboarded bench for branch_resolve_unit: directed cases then random
// traffic against a cycle-level reference model. Honours BRANCH_STATS_EN.
module tb_branch_resolve_unit;

  localparam int F = 2;

  logic        clk = 1'b0;
  logic        rst, flag_we, sign_in, carry_in, zero_in, br_valid;
  logic [5:0]  opcode;
  logic [31:0] pc, offset, rs_val;
  logic        busy, redirect, flush, link_we;
  logic [31:0] target, link_addr;
  logic [2:0]  flags;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_resolved, stat_taken;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.ADDR_W(32), .DATA_W(32), .PC_INC(4), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .sign_in(sign_in), .carry_in(carry_in),
    .zero_in(zero_in), .br_valid(br_valid), .opcode(opcode), .pc(pc), .offset(offset),
    .rs_val(rs_val), .busy(busy), .redirect(redirect), .target(target), .flush(flush),
    .link_we(link_we), .link_addr(link_addr), .flags(flags)
`ifdef BRANCH_STATS_EN
    , .stat_resolved(stat_resolved), .stat_taken(stat_taken)
`endif
  );

  typedef struct { logic [31:0] tgt; logic lw; logic [31:0] la; } exp_t;
  exp_t q[$];

  int n_vec = 0, n_err = 0;
  bit mon_en = 0;
  logic [2:0] m_flags;
  int m_busy_left;
  longint m_res, m_tak;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [5:0] op, input logic [2:0] f);
    bit s = f[2], c = f[1], z = f[0];
    case (op)
      6'o07: return s && !z;
      6'o10: return !s && z;
      6'o11: return !z;
      6'o12, 6'o13, 6'o14: return 1;
      6'o15: return c;
      6'o16: return !c;
      default: return 0;
    endcase
  endfunction

  task automatic step(input bit r, input bit fwe, input logic [2:0] fin, input bit bv,
                      input logic [5:0] op, input logic [31:0] p, input logic [31:0] off,
                      input logic [31:0] rs);
    logic [2:0] eff;
    bit take, acc;
    exp_t e;
    rst = r; flag_we = fwe; {sign_in, carry_in, zero_in} = fin;
    br_valid = bv; opcode = op; pc = p; offset = off; rs_val = rs;
    eff  = fwe ? fin : m_flags;
    acc  = !r && bv && (m_busy_left == 0);
    take = acc && ref_taken(op, eff);
    e.tgt = (op == 6'o12) ? rs : p + off;
    e.lw  = (op == 6'o14);
    e.la  = p + 32'd4;
    @(posedge clk);
    #1;
    if (r) begin
      m_flags = 0; m_busy_left = 0; m_res = 0; m_tak = 0;
      q.delete();
    end else begin
      if (fwe) m_flags = fin;
      if (take) m_busy_left = F;
      else if (m_busy_left > 0) m_busy_left--;
      if (acc && op >= 6'o07 && op <= 6'o16) m_res++;
      if (take) begin m_tak++; q.push_back(e); end
    end
    mon_en = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'b000, 0, 6'd0, 0, 0, 0);
  endtask

  // Monitor: compares DUT outputs with the model and pops the scoreboard.
  always @(negedge clk) if (mon_en) begin
    exp_t e;
    chk("busy",  {31'd0, busy},  {31'd0, m_busy_left > 0});
    chk("flush", {31'd0, flush}, {31'd0, m_busy_left > 0});
    chk("flags", {29'd0, flags}, {29'd0, m_flags});
`ifdef BRANCH_STATS_EN
    chk("stat_resolved", stat_resolved, 32'(m_res));
    chk("stat_taken",    stat_taken,    32'(m_tak));
`endif
    if (redirect) begin
      if (q.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("target",  target, e.tgt);
        chk("link_we", {31'd0, link_we}, {31'd0, e.lw});
        if (e.lw) chk("link_addr", link_addr, e.la);
      end
    end else begin
      chk("link_we_idle", {31'd0, link_we}, 32'd0);
      if (q.size() != 0) begin
        void'(q.pop_front());
        chk("missing_redirect", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    m_flags = 0; m_busy_left = 0; m_res = 0; m_tak = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_target",    target,    32'd0);
    chk("reset_link_addr", link_addr, 32'd0);
    chk("reset_redirect",  {31'd0, redirect}, 32'd0);

    // bltz taken with latched S
    step(0, 1, 3'b100, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 6'o07, 32'h100, 32'h20, 0);
    chk("bltz_target", target, 32'h120);
    idle(3);
    // bnz not taken on Z, then taken through bypass
    step(0, 1, 3'b001, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 6'o11, 32'h40, 32'h8, 0);
    step(0, 1, 3'b000, 1, 6'o11, 32'h40, 32'h8, 0);
    idle(3);
    // bl with negative offset, then br via register
    step(0, 0, 0, 1, 6'o14, 32'h1000, 32'hFFFF_FFF0, 0);
    chk("bl_target", target, 32'h0FF0);
    chk("bl_link",   link_addr, 32'h1004);
    idle(3);
    step(0, 0, 0, 1, 6'o12, 32'h200, 32'h4, 32'hDEAD_BEEC);
    chk("br_target", target, 32'hDEAD_BEEC);
    idle(3);
    // wrap, ignored while busy, accepted when busy falls
    step(0, 0, 0, 1, 6'o13, 32'hFFFF_FFFC, 32'h8, 0);
    chk("b_wrap", target, 32'h4);
    step(0, 0, 0, 1, 6'o13, 32'h500, 32'h10, 0);
    step(0, 0, 0, 1, 6'o13, 32'h600, 32'h10, 0);
    step(0, 0, 0, 1, 6'o13, 32'h700, 32'h10, 0);
    chk("b2b_target", target, 32'h710);
    idle(3);
    // reset in first flush cycle aborts it
    step(0, 0, 0, 1, 6'o13, 32'h800, 32'h10, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_abort_busy", {31'd0, busy}, 32'd0);
    step(0, 0, 0, 1, 6'o13, 32'h900, 32'h10, 0);
    chk("post_rst_target", target, 32'h910);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(7, 14));
      step(($urandom_range(0, 59) == 0), $urandom_range(0, 1), 3'($urandom),
           $urandom_range(0, 1), op, $urandom, $urandom, $urandom);
    end
    idle(4);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
